// File: rtl/dmem_pkg.sv
// Shared types, widths and the address-error predicate for the data-memory responder.
package dmem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // An access is rejected when it is not word aligned or falls beyond the storage.
   function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/acknowledge bus between the memory stage (master) and the responder (slave).
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              i_req;
   logic              i_we;
   logic [WORD_W-1:0] i_addr;
   logic [WORD_W-1:0] i_wdata;
   logic [BE_W-1:0]   i_be;
   logic              o_ready;
   logic              o_ack;
   logic              o_err;
   logic [WORD_W-1:0] o_rdata;

   modport slave (
      input  i_req, i_we, i_addr, i_wdata, i_be,
      output o_ready, o_ack, o_err, o_rdata
   );

   modport master (
      output i_req, i_we, i_addr, i_wdata, i_be,
      input  o_ready, o_ack, o_err, o_rdata
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
// The read register doubles as the responder's load-data output, so it carries
// its own reset and a clear used to zero the data on rejected accesses.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_we,
   input  logic              i_clr,
   input  logic [AW-1:0]     i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [BE_W-1:0]   i_be,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rdata;

   // Byte-lane writes; contents are intentionally never reset.
   always_ff @(posedge i_clk) begin
      if (i_en && i_we) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (i_be[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   // Read register: holds until the next load, clear or reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_clr) begin
         r_rdata <= '0;
      end else if (i_en && !i_we) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES
// wait states, then returns a one-cycle acknowledge with read data or an error.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   dmem_responder_if.slave  bus
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic              r_we;
   logic [WORD_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;
   logic              r_ack;
   logic              r_err;

   logic              w_ready;
   logic              w_accept;
   logic              w_enter_resp;
   logic              w_acc_we;
   logic [WORD_W-1:0] w_acc_addr;
   logic [WORD_W-1:0] w_acc_wdata;
   logic [BE_W-1:0]   w_acc_be;
   logic              w_err;
   logic              w_mem_en;
   logic              w_mem_clr;
   logic [WORD_W-1:0] w_rdata;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Handshake and access control. With zero wait states the access happens on
   // the accept edge itself, so the live request fields bypass the capture regs.
   always_comb begin
      w_ready      = (r_state == ST_IDLE) && !i_rst;
      w_accept     = w_ready && bus.i_req;
      w_enter_resp = 1'b0;
      if ((r_state == ST_WAIT) && (r_cnt == '0)) begin
         w_enter_resp = 1'b1;
      end
      if (w_accept && (WAIT_CYCLES == 0)) begin
         w_enter_resp = 1'b1;
      end
      if (r_state == ST_IDLE) begin
         w_acc_we    = bus.i_we;
         w_acc_addr  = bus.i_addr;
         w_acc_wdata = bus.i_wdata;
         w_acc_be    = bus.i_be;
      end else begin
         w_acc_we    = r_we;
         w_acc_addr  = r_addr;
         w_acc_wdata = r_wdata;
         w_acc_be    = r_be;
      end
      w_err     = addr_err(w_acc_addr, DEPTH);
      w_mem_en  = w_enter_resp && !i_rst && !w_err;
      w_mem_clr = w_enter_resp && !i_rst && w_err;
   end

   // Wait-state counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Request capture on acceptance.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_we    <= bus.i_we;
         r_addr  <= bus.i_addr;
         r_wdata <= bus.i_wdata;
         r_be    <= bus.i_be;
      end
   end

   // Registered acknowledge and error, asserted for the single RESP cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_ack <= w_enter_resp;
         r_err <= w_enter_resp && w_err;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (w_mem_en),
      .i_we    (w_acc_we),
      .i_clr   (w_mem_clr),
      .i_addr  (w_acc_addr[AW+1:2]),
      .i_wdata (w_acc_wdata),
      .i_be    (w_acc_be),
      .o_rdata (w_rdata)
   );

   assign bus.o_ready = w_ready;
   assign bus.o_ack   = r_ack;
   assign bus.o_err   = r_err;
   assign bus.o_rdata = w_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance driven from a vector table
// and a 0-wait-state instance for back-to-back requests.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned WA    = 2;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   always #5 clk = ~clk;

   dmem_responder_if u_if_a ();
   dmem_responder_if u_if_b ();

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WA)) u_dut_a (
      .i_clk (clk),
      .i_rst (rst_a),
      .bus   (u_if_a)
   );

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
      .i_clk (clk),
      .i_rst (rst_b),
      .bus   (u_if_b)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_err;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      logic        err;
      logic        chk_rd;
      logic [31:0] rd;
   } exp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be, input logic err, input logic chk,
                               input logic [31:0] rd);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = wd; v.be = be;
      v.exp_err = err; v.chk_rd = chk; v.exp_rd = rd;
      return v;
   endfunction

   function automatic logic ready_of(input int d);
      return (d == 0) ? u_if_a.o_ready : u_if_b.o_ready;
   endfunction
   function automatic logic ack_of(input int d);
      return (d == 0) ? u_if_a.o_ack : u_if_b.o_ack;
   endfunction
   function automatic logic err_of(input int d);
      return (d == 0) ? u_if_a.o_err : u_if_b.o_err;
   endfunction
   function automatic logic [31:0] rdata_of(input int d);
      return (d == 0) ? u_if_a.o_rdata : u_if_b.o_rdata;
   endfunction

   task automatic drive(input int d, input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (d == 0) begin
         u_if_a.i_req = req; u_if_a.i_we = we; u_if_a.i_addr = addr;
         u_if_a.i_wdata = wdata; u_if_a.i_be = be;
      end else begin
         u_if_b.i_req = req; u_if_b.i_we = we; u_if_b.i_addr = addr;
         u_if_b.i_wdata = wdata; u_if_b.i_be = be;
      end
   endtask

   // One complete access: request in cycle 0, expect ack in cycle lat+1.
   task automatic access(input int d, input int unsigned lat, input string tag, input vec_t v);
      exp_t e;
      bit   seen;
      @(negedge clk);
      check({tag, "_ready"}, ready_of(d), 1'b1);
      drive(d, 1'b1, v.we, v.addr, v.wdata, v.be);
      e.err = v.exp_err; e.chk_rd = v.chk_rd; e.rd = v.exp_rd;
      sb.push_back(e);
      @(posedge clk);
      #1 drive(d, 1'b0, 1'b0, '0, '0, '0);
      seen = 1'b0;
      for (int unsigned c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (ack_of(d)) begin
            seen = 1'b1;
            check({tag, "_ack_cycle"}, c, lat + 1);
            check({tag, "_ready_on_ack"}, ready_of(d), 1'b0);
            e = sb.pop_front();
            check({tag, "_err"}, err_of(d), e.err);
            if (e.chk_rd) check({tag, "_rdata"}, rdata_of(d), e.rd);
         end
      end
      if (!seen) begin
         check({tag, "_ack_timeout"}, 1'b0, 1'b1);
         void'(sb.pop_front());
      end
   endtask

   initial begin
      logic        exp_ack;
      int unsigned k;
      exp_t        e;

      vecs[0]  = mk(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0);
      vecs[1]  = mk(1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF);
      vecs[2]  = mk(1'b1, 32'h10,       32'h000000AA, 4'h1, 1'b0, 1'b1, 32'hDEADBEEF);
      vecs[3]  = mk(1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEAA);
      vecs[4]  = mk(1'b0, 32'h13,       32'h0,        4'hF, 1'b1, 1'b1, 32'h0);
      vecs[5]  = mk(1'b0, DEPTH*4,      32'h0,        4'hF, 1'b1, 1'b1, 32'h0);
      vecs[6]  = mk(1'b1, 32'h0,        32'h01020304, 4'hF, 1'b0, 1'b0, 32'h0);
      vecs[7]  = mk(1'b1, 32'h12,       32'h11111111, 4'hF, 1'b1, 1'b0, 32'h0);
      vecs[8]  = mk(1'b1, DEPTH*4,      32'h22222222, 4'hF, 1'b1, 1'b0, 32'h0);
      vecs[9]  = mk(1'b0, 32'h0,        32'h0,        4'hF, 1'b0, 1'b1, 32'h01020304);
      vecs[10] = mk(1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 32'h01020304);
      vecs[11] = mk(1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEAA);
      vecs[12] = mk(1'b1, 32'h10,       32'h00556600, 4'h6, 1'b0, 1'b1, 32'hDEADBEAA);
      vecs[13] = mk(1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDE5566AA);
      vecs[14] = mk(1'b1, 32'h3FC,      32'h0,        4'hF, 1'b0, 1'b1, 32'hDE5566AA);
      vecs[15] = mk(1'b1, 32'h3FC,      32'hCAFEF00D, 4'hC, 1'b0, 1'b1, 32'hDE5566AA);
      vecs[16] = mk(1'b0, 32'h3FC,      32'h0,        4'hF, 1'b0, 1'b1, 32'hCAFE0000);
      vecs[17] = mk(1'b1, 32'h20,       32'h12345678, 4'hF, 1'b0, 1'b1, 32'hCAFE0000);
      vecs[18] = mk(1'b0, 32'h20,       32'h0,        4'hF, 1'b0, 1'b1, 32'h12345678);
      vecs[19] = mk(1'b0, 32'h80000010, 32'h0,        4'hF, 1'b1, 1'b1, 32'h0);

      rst_a = 1'b1;
      rst_b = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);

      // Power-on reset held three cycles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("por_ready_%0d", i), u_if_a.o_ready, 1'b0);
         check($sformatf("por_ack_%0d", i),   u_if_a.o_ack,   1'b0);
         check($sformatf("por_err_%0d", i),   u_if_a.o_err,   1'b0);
         check($sformatf("por_rdata_%0d", i), u_if_a.o_rdata, 32'h0);
         check($sformatf("por_b_ready_%0d", i), u_if_b.o_ready, 1'b0);
      end
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Table-driven accesses on the two-wait-state instance.
      for (int i = 0; i < 20; i++) begin
         access(0, WA, $sformatf("vec%0d", i), vecs[i]);
      end

      // Reset during the first WAIT cycle drops the store.
      @(negedge clk);
      check("rstw1_ready", u_if_a.o_ready, 1'b1);
      drive(0, 1'b1, 1'b1, 32'h20, 32'hFFFF0000, 4'hF);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("rstw1_no_ack_%0d", i), u_if_a.o_ack, 1'b0);
      end

      // Reset on the edge that would enter RESP also drops the store.
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555, 4'hF);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("rstw2_no_ack_%0d", i), u_if_a.o_ack, 1'b0);
      end
      access(0, WA, "rst_reload", mk(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 32'h12345678));

      // Reset held three cycles clears a non-zero read register.
      @(negedge clk);
      rst_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst3_ready_%0d", i), u_if_a.o_ready, 1'b0);
         check($sformatf("rst3_ack_%0d", i),   u_if_a.o_ack,   1'b0);
         check($sformatf("rst3_err_%0d", i),   u_if_a.o_err,   1'b0);
         check($sformatf("rst3_rdata_%0d", i), u_if_a.o_rdata, 32'h0);
      end
      rst_a = 1'b0;
      @(negedge clk);
      check("rst3_ready_after", u_if_a.o_ready, 1'b1);

      // Zero-wait instance: preload four words.
      for (int i = 0; i < 4; i++) begin
         access(1, 0, $sformatf("bst%0d", i),
                mk(1'b1, 32'h40 + 32'(4*i), 32'hB0000000 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0));
      end

      // Request held high across four loads: acks in cycles 1,3,5,7.
      @(negedge clk);
      check("hold_ready0", u_if_b.o_ready, 1'b1);
      drive(1, 1'b1, 1'b0, 32'h40, '0, '0);
      e.err = 1'b0; e.chk_rd = 1'b1; e.rd = 32'hB0000000;
      sb.push_back(e);
      k = 1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         exp_ack = ((c % 2) == 1) && (c <= 7);
         check($sformatf("hold_ack_c%0d", c),   u_if_b.o_ack,   exp_ack);
         check($sformatf("hold_ready_c%0d", c), u_if_b.o_ready, !exp_ack);
         if (u_if_b.o_ack) begin
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check($sformatf("hold_err_c%0d", c),   u_if_b.o_err,   e.err);
               check($sformatf("hold_rdata_c%0d", c), u_if_b.o_rdata, e.rd);
            end else begin
               check($sformatf("hold_extra_ack_c%0d", c), 1'b1, 1'b0);
            end
         end
         if (((c % 2) == 0) && (k < 4)) begin
            drive(1, 1'b1, 1'b0, 32'h40 + 32'(4*k), '0, '0);
            e.err = 1'b0; e.chk_rd = 1'b1; e.rd = 32'hB0000000 + 32'(k);
            sb.push_back(e);
            k++;
         end
         if (c == 7) drive(1, 1'b0, 1'b0, '0, '0, '0);
      end
      check("sb_empty", 32'(sb.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
